// File: rtl/modulo_transferencia_rolhas.sv
// Cork transfer sequencer: moves corks one per clock from the reserve into the
// capping dispenser, strobing the external counters and reporting the amount moved.
module modulo_transferencia_rolhas #(
    parameter int RES_W     = 7,
    parameter int DISP_W    = 4,
    parameter int DISP_MAX  = 15,
    parameter int NIVEL_MIN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              transfer_rolhas,
    input  logic [RES_W-1:0]  reg_r,
    input  logic [DISP_W-1:0] reg_d,
    output logic              dec_r,
    output logic              inc_d,
    output logic              busy,
    output logic              done,
    output logic [DISP_W-1:0] qtd_transf
);

    localparam int CALC_W = RES_W + 1;
    localparam logic [CALC_W-1:0] DISP_MAX_C  = CALC_W'(DISP_MAX);
    localparam logic [CALC_W-1:0] CNT_LIMIT   = CALC_W'((1 << DISP_W) - 1);
    localparam logic [DISP_W-1:0] NIVEL_MIN_C = DISP_W'(NIVEL_MIN);
    localparam logic [DISP_W-1:0] ONE_D       = DISP_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        MOVE,
        DONE
    } state_t;

    state_t              state;
    logic [DISP_W-1:0]   n;
    logic [DISP_W-1:0]   cnt;
    logic [DISP_W-1:0]   cnt_next;
    logic [DISP_W-1:0]   n_calc;
    logic [CALC_W-1:0]   reg_d_ext;
    logic [CALC_W-1:0]   reg_r_ext;
    logic [CALC_W-1:0]   room;
    logic [CALC_W-1:0]   n_wide;
    logic                start_req;
    logic                strobe_ok;

    // Transfer size is worked out one bit wider than the reserve so the
    // subtraction and the min() never wrap before being clamped to DISP_W bits.
    always_comb begin
        reg_d_ext = CALC_W'(reg_d);
        reg_r_ext = CALC_W'(reg_r);
        room      = (reg_d_ext >= DISP_MAX_C) ? '0 : (DISP_MAX_C - reg_d_ext);
        n_wide    = (room < reg_r_ext) ? room : reg_r_ext;
        n_calc    = (n_wide > CNT_LIMIT) ? '1 : n_wide[DISP_W-1:0];
    end

    assign start_req = enable & transfer_rolhas & (reg_d < NIVEL_MIN_C);
    assign strobe_ok = enable & (cnt < n);
    assign cnt_next  = cnt + ONE_D;

    // n latched in CALC is authoritative; the external counters lag the strobes
    // by a cycle, so reg_r/reg_d are never consulted again until the next IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dec_r      <= 1'b0;
            inc_d      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            qtd_transf <= '0;
            n          <= '0;
            cnt        <= '0;
        end else begin
            dec_r <= 1'b0;
            inc_d <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    n   <= n_calc;
                    cnt <= '0;
                    if (n_calc == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        state <= MOVE;
                        busy  <= 1'b1;
                    end
                end
                MOVE: begin
                    if (strobe_ok) begin
                        dec_r <= 1'b1;
                        inc_d <= 1'b1;
                        cnt   <= cnt_next;
                        if (cnt_next == n) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end else if (cnt >= n) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    done       <= 1'b1;
                    qtd_transf <= cnt;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_transferencia_rolhas.sv
// Directed bench for the cork transfer sequencer; models the external reserve and
// dispenser registers so strobe counts and conservation can be checked.
module tb_modulo_transferencia_rolhas;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       transfer_rolhas;
    logic [6:0] reg_r;
    logic [3:0] reg_d;
    logic       dec_r;
    logic       inc_d;
    logic       busy;
    logic       done;
    logic [3:0] qtd_transf;

    int checks;
    int failures;
    int cyc;
    int cyc0;
    int model_r;
    int model_d;
    int strobes;
    int first_strobe;
    int last_strobe;
    int pair_bad;
    int busy_cycles;
    int done_seen;
    int last_done;
    int max_d;

    modulo_transferencia_rolhas dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .transfer_rolhas (transfer_rolhas),
        .reg_r           (reg_r),
        .reg_d           (reg_d),
        .dec_r           (dec_r),
        .inc_d           (inc_d),
        .busy            (busy),
        .done            (done),
        .qtd_transf      (qtd_transf)
    );

    always #5 clk = ~clk;

    task automatic set_regs(input int r, input int d);
        model_r = r;
        model_d = d;
        reg_r   = 7'(r);
        reg_d   = 4'(d);
    endtask

    task automatic clear_stats();
        strobes      = 0;
        first_strobe = -1;
        last_strobe  = -1;
        pair_bad     = 0;
        busy_cycles  = 0;
        done_seen    = 0;
        last_done    = -1;
        max_d        = model_d;
    endtask

    // One clock: sample just after the edge and let the external registers follow the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (dec_r === 1'b1) begin
            strobes++;
            last_strobe = cyc;
            if (first_strobe < 0) first_strobe = cyc;
            model_r = model_r - 1;
        end
        if (inc_d === 1'b1) model_d = model_d + 1;
        if (dec_r !== inc_d) pair_bad++;
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) begin
            done_seen++;
            last_done = cyc;
        end
        if (model_d > max_d) max_d = model_d;
        reg_r = 7'(model_r);
        reg_d = 4'(model_d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (dec_r !== 1'b0) begin failures++; $display("[TB] FAIL reset_dec_r: got %b expected 0", dec_r); end
        checks++; if (inc_d !== 1'b0) begin failures++; $display("[TB] FAIL reset_inc_d: got %b expected 0", inc_d); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (qtd_transf !== 4'd0) begin failures++; $display("[TB] FAIL reset_qtd: got %0d expected 0", qtd_transf); end
        enable          = 1'b1;
        transfer_rolhas = 1'b1;
        set_regs(20, 10);
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_hold_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (busy_cycles !== 0) begin failures++; $display("[TB] FAIL idle_high_level_busy: got %0d expected 0", busy_cycles); end
        transfer_rolhas = 1'b0;
    endtask

    task automatic test_full_refill();
        set_regs(20, 0);
        clear_stats();
        transfer_rolhas = 1'b1;
        cyc0 = cyc;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL full_busy_calc: got %b expected 1", busy); end
        for (int i = 0; i < 24; i++) tick();
        checks++; if (strobes !== 15) begin failures++; $display("[TB] FAIL full_strobes: got %0d expected 15", strobes); end
        checks++; if (first_strobe !== cyc0 + 3) begin failures++; $display("[TB] FAIL full_first_strobe: got %0d expected %0d", first_strobe, cyc0 + 3); end
        checks++; if (last_strobe !== cyc0 + 17) begin failures++; $display("[TB] FAIL full_last_strobe: got %0d expected %0d", last_strobe, cyc0 + 17); end
        checks++; if (last_done !== cyc0 + 18) begin failures++; $display("[TB] FAIL full_done_cycle: got %0d expected %0d", last_done, cyc0 + 18); end
        checks++; if (done_seen !== 1) begin failures++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_seen); end
        checks++; if (qtd_transf !== 4'd15) begin failures++; $display("[TB] FAIL full_qtd: got %0d expected 15", qtd_transf); end
        checks++; if (model_r !== 5 || model_d !== 15) begin failures++; $display("[TB] FAIL full_regs: got r=%0d d=%0d expected r=5 d=15", model_r, model_d); end
        checks++; if (pair_bad !== 0) begin failures++; $display("[TB] FAIL full_pairing: got %0d expected 0", pair_bad); end
        checks++; if (busy_cycles !== 16) begin failures++; $display("[TB] FAIL full_busy_cycles: got %0d expected 16", busy_cycles); end
        transfer_rolhas = 1'b0;
    endtask

    task automatic test_partial_refill();
        set_regs(40, 4);
        clear_stats();
        transfer_rolhas = 1'b1;
        cyc0 = cyc;
        tick();
        transfer_rolhas = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (strobes !== 11) begin failures++; $display("[TB] FAIL partial_strobes: got %0d expected 11", strobes); end
        checks++; if (qtd_transf !== 4'd11) begin failures++; $display("[TB] FAIL partial_qtd: got %0d expected 11", qtd_transf); end
        checks++; if (last_done !== cyc0 + 14) begin failures++; $display("[TB] FAIL partial_done_cycle: got %0d expected %0d", last_done, cyc0 + 14); end
        checks++; if (model_r !== 29 || model_d !== 15) begin failures++; $display("[TB] FAIL partial_regs: got r=%0d d=%0d expected r=29 d=15", model_r, model_d); end
    endtask

    task automatic test_level_block();
        set_regs(40, 5);
        clear_stats();
        transfer_rolhas = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        transfer_rolhas = 1'b0;
        checks++; if (strobes !== 0) begin failures++; $display("[TB] FAIL block_strobes: got %0d expected 0", strobes); end
        checks++; if (busy_cycles !== 0) begin failures++; $display("[TB] FAIL block_busy: got %0d expected 0", busy_cycles); end
        checks++; if (done_seen !== 0) begin failures++; $display("[TB] FAIL block_done: got %0d expected 0", done_seen); end
        checks++; if (qtd_transf !== 4'd11) begin failures++; $display("[TB] FAIL block_qtd_kept: got %0d expected 11", qtd_transf); end
    endtask

    task automatic test_reserve_limited();
        set_regs(3, 0);
        clear_stats();
        transfer_rolhas = 1'b1;
        cyc0 = cyc;
        tick();
        transfer_rolhas = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (strobes !== 3) begin failures++; $display("[TB] FAIL reserve_strobes: got %0d expected 3", strobes); end
        checks++; if (qtd_transf !== 4'd3) begin failures++; $display("[TB] FAIL reserve_qtd: got %0d expected 3", qtd_transf); end
        checks++; if (last_done !== cyc0 + 6) begin failures++; $display("[TB] FAIL reserve_done_cycle: got %0d expected %0d", last_done, cyc0 + 6); end
        checks++; if (model_r !== 0 || model_d !== 3) begin failures++; $display("[TB] FAIL reserve_regs: got r=%0d d=%0d expected r=0 d=3", model_r, model_d); end
    endtask

    task automatic test_zero_transfer();
        set_regs(0, 0);
        clear_stats();
        transfer_rolhas = 1'b1;
        cyc0 = cyc;
        tick();
        transfer_rolhas = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (strobes !== 0) begin failures++; $display("[TB] FAIL zero_strobes: got %0d expected 0", strobes); end
        checks++; if (done_seen !== 1) begin failures++; $display("[TB] FAIL zero_done_count: got %0d expected 1", done_seen); end
        checks++; if (last_done !== cyc0 + 3) begin failures++; $display("[TB] FAIL zero_done_cycle: got %0d expected %0d", last_done, cyc0 + 3); end
        checks++; if (qtd_transf !== 4'd0) begin failures++; $display("[TB] FAIL zero_qtd: got %0d expected 0", qtd_transf); end
    endtask

    // Request held high across DONE with the dispenser still low restarts immediately.
    task automatic test_back_to_back();
        set_regs(3, 0);
        clear_stats();
        transfer_rolhas = 1'b1;
        cyc0 = cyc;
        for (int i = 0; i < 9; i++) tick();
        transfer_rolhas = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (done_seen !== 2) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_seen); end
        checks++; if (last_done !== cyc0 + 9) begin failures++; $display("[TB] FAIL b2b_second_done: got %0d expected %0d", last_done, cyc0 + 9); end
        checks++; if (strobes !== 3) begin failures++; $display("[TB] FAIL b2b_strobes: got %0d expected 3", strobes); end
        checks++; if (qtd_transf !== 4'd0) begin failures++; $display("[TB] FAIL b2b_qtd: got %0d expected 0", qtd_transf); end
    endtask

    task automatic test_enable_pause();
        set_regs(20, 0);
        clear_stats();
        transfer_rolhas = 1'b1;
        cyc0 = cyc;
        tick();
        transfer_rolhas = 1'b0;
        for (int i = 0; i < 10 && strobes < 2; i++) tick();
        checks++; if (cyc !== cyc0 + 4) begin failures++; $display("[TB] FAIL pause_second_strobe: got %0d expected %0d", cyc, cyc0 + 4); end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (strobes !== 2) begin failures++; $display("[TB] FAIL pause_no_strobes: got %0d expected 2", strobes); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL pause_busy_held: got %b expected 1", busy); end
        enable = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        checks++; if (strobes !== 15) begin failures++; $display("[TB] FAIL pause_total: got %0d expected 15", strobes); end
        checks++; if (last_done !== cyc0 + 22) begin failures++; $display("[TB] FAIL pause_done_cycle: got %0d expected %0d", last_done, cyc0 + 22); end
        checks++; if (qtd_transf !== 4'd15) begin failures++; $display("[TB] FAIL pause_qtd: got %0d expected 15", qtd_transf); end
    endtask

    task automatic test_reset_mid_move();
        set_regs(20, 0);
        clear_stats();
        transfer_rolhas = 1'b1;
        cyc0 = cyc;
        tick();
        transfer_rolhas = 1'b0;
        for (int i = 0; i < 15 && strobes < 7; i++) tick();
        checks++; if (strobes !== 7) begin failures++; $display("[TB] FAIL rstmid_reach7: got %0d expected 7", strobes); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dec_r !== 1'b0 || inc_d !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_strobes: got dec_r=%b inc_d=%b expected 0 0", dec_r, inc_d); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy_done: got busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (qtd_transf !== 4'd0) begin failures++; $display("[TB] FAIL rstmid_qtd: got %0d expected 0", qtd_transf); end
        tick();
        rst_n = 1'b1;
        checks++; if (model_r + model_d !== 20) begin failures++; $display("[TB] FAIL rstmid_conserved: got %0d expected 20", model_r + model_d); end
        set_regs(model_r, model_d - 5);
        clear_stats();
        transfer_rolhas = 1'b1;
        cyc0 = cyc;
        tick();
        transfer_rolhas = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_restart_busy: got %b expected 1", busy); end
        for (int i = 0; i < 20; i++) tick();
        checks++; if (first_strobe !== cyc0 + 3) begin failures++; $display("[TB] FAIL rstmid_restart_first: got %0d expected %0d", first_strobe, cyc0 + 3); end
        checks++; if (strobes !== 13 || qtd_transf !== 4'd13) begin failures++; $display("[TB] FAIL rstmid_restart_qtd: got strobes=%0d qtd=%0d expected 13 13", strobes, qtd_transf); end
    endtask

    task automatic test_consumption();
        set_regs(20, 0);
        clear_stats();
        transfer_rolhas = 1'b1;
        tick();
        transfer_rolhas = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 4 || i == 7 || i == 10) set_regs(model_r, model_d - 1);
        end
        checks++; if (strobes !== 15) begin failures++; $display("[TB] FAIL consume_strobes: got %0d expected 15", strobes); end
        checks++; if (model_d !== 12) begin failures++; $display("[TB] FAIL consume_final_d: got %0d expected 12", model_d); end
        checks++; if (max_d > 15) begin failures++; $display("[TB] FAIL consume_max_d: got %0d expected at most 15", max_d); end
        checks++; if (qtd_transf !== 4'd15 || model_r !== 5) begin failures++; $display("[TB] FAIL consume_qtd_r: got qtd=%0d r=%0d expected 15 5", qtd_transf, model_r); end
    endtask

    initial begin
        clk             = 1'b0;
        rst_n           = 1'b0;
        enable          = 1'b0;
        transfer_rolhas = 1'b0;
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        set_regs(0, 0);
        clear_stats();
        test_reset();
        test_full_refill();
        test_partial_refill();
        test_level_block();
        test_reserve_limited();
        test_zero_transfer();
        test_back_to_back();
        test_enable_pause();
        test_reset_mid_move();
        test_consumption();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
